xadc_drp_arbiter: RTL and testbench
===================================

# xadc_drp_arbiter

Round-robin arbiter and sequencer for the XADC Dynamic Reconfiguration Port (DRP). It lets several independent consumers share the single DRP read port: the joystick X/Y readers, an on-die temperature monitor, and a spare. It sits between those consumers and the `xadc_wiz_0` instance. It owns `den`/`daddr`, serialises reads, returns `do` to the granted requester with a one-cycle acknowledge, and recovers from a missing `drdy` via timeout.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: maximum number of WAIT cycles for `drdy_in` before the read is aborted (1..1023).

Ports:
- `clk_100MHz`  in  1: single clock; also drives the XADC `dclk_in`.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  N_REQ: per-requester read request, level. Held until the matching `ack` bit pulses.
- `req_addr`  in  7*N_REQ: packed DRP addresses; slice i is `[7*i+6:7*i]`. Sampled only at grant.
- `ack`  out  N_REQ: one-hot, single-cycle completion pulse to the granted requester.
- `err`  out  1: single-cycle pulse coincident with `ack` when the read timed out.
- `rdata`  out  16: read data. Valid while `ack` is high and held until the next completion.
- `busy`  out  1: high from grant through completion.
- `daddr_out`  out  7: to XADC `daddr_in`.
- `den_out`  out  1: to XADC `den_in`.
- `dwe_out`  out  1: tied 0, because this block only reads.
- `drdy_in`  in  1: from XADC `drdy_out`.
- `do_in`  in  16: from XADC `do_out`.

## Operation
- The FSM has three states: IDLE, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - If `req != 0`, pick the winner by round-robin, starting at pointer `rr_ptr` and searching upward with wrap.
  - Register the winner index `g`, drive `daddr_out <= req_addr[g]` and `den_out <= 1`, set `busy <= 1`, clear the timeout counter, and go to WAIT.
  - If `req == 0`, stay in IDLE.
- **WAIT**
  - `den_out <= 0`, so `den` is high for exactly one cycle.
  - If `drdy_in`: `rdata <= do_in`, `ack[g] <= 1`, go to DONE.
  - Else, if the counter equals `TIMEOUT-1`: `ack[g] <= 1`, `err <= 1`, `rdata <= 16'hFFFF`, go to DONE.
  - Else increment the counter.
- **DONE**
  - `ack <= 0`, `err <= 0`, `busy <= 0`, `rr_ptr <= (g+1) mod N_REQ`, go to IDLE.
- `drdy_in` received in IDLE or DONE (late or spurious) is ignored, and `rdata` is not updated.
- If `req[g]` drops during WAIT, the transaction still completes and the `ack` pulse is still issued.
- Requesters that are not granted are unaffected. A request that is withdrawn before it is granted is never serviced.
- Synchronous reset in any state forces all of the following at the next edge: state IDLE, `den_out 0`, `daddr_out 0`, `ack 0`, `err 0`, `busy 0`, `rdata 0`, `rr_ptr 0`, counter 0. An in-flight read is abandoned and its late `drdy` is ignored.
- Width rules:
  - The counter is `$clog2(TIMEOUT+1)` bits.
  - `rr_ptr` and `g` are `$clog2(N_REQ)` bits (minimum 1).
  - Pointer wrap is explicit: `N_REQ-1 -> 0`.

## Timing
- Reset values: `ack 0`, `err 0`, `rdata 16'h0000`, `busy 0`, `daddr_out 7'h00`, `den_out 0`, `dwe_out 0`.
- When `req` is seen at edge k in IDLE:
  - `den_out` and `busy` are high during cycle k..k+1.
  - `daddr_out` is stable from edge k until the next grant.
- If `drdy_in` is high at edge k+d (d ≥ 1), then `ack` and `rdata` are valid in cycle k+d..k+d+1.
- The next grant can occur at edge k+d+2. Best-case throughput is one read per d+2 cycles.
- Timeout: `ack` and `err` assert after edge k+TIMEOUT if no `drdy_in` is seen.
- `ack` and `err` are never high for more than one cycle. No two `ack` bits are ever high at the same time.

## Structure
- Package `xadc_pkg`:
  - FSM state enum (IDLE/WAIT/DONE).
  - DRP channel address constants: `ADDR_TEMP=7'h00`, `ADDR_VAUX6=7'h16`, `ADDR_VAUX7=7'h17`.
  - Timeout default.
  - `RDATA_TIMEOUT=16'hFFFF`.
- Sub-module `rr_picker`: a combinational round-robin selector with inputs `req[N_REQ]` and `rr_ptr`, and outputs `gnt_idx` and `gnt_valid`. It is instantiated once.
- The top level holds the FSM, counter, pointer, and output registers.

## Test plan
- **Single read:** `req=4'b0010`, `req_addr[1]=7'h16`, XADC model returns `drdy` 3 cycles after `den` with `do=16'hA5A0` → `den` is high for 1 cycle with `daddr=7'h16`; `ack=4'b0010` and `rdata=16'hA5A0` for exactly 1 cycle; `err=0`.
- **Fairness:** `req=4'b1111` held, with each requester dropping its request after its `ack` and re-raising it one cycle later → grant order is 0,1,2,3,0,1… and no requester is granted twice in a row while others are pending.
- **Timeout:** `TIMEOUT=8`, model never asserts `drdy`, `req[2]=1` → `ack[2]` and `err` pulse exactly 8 cycles after the `den` cycle; `rdata=16'hFFFF`; the next request is serviced normally.
- **Spurious/late `drdy`:** `drdy_in=1` with `do=16'h1234` pulsed while IDLE → no `ack`, `rdata` unchanged. Then reset mid-WAIT followed by `drdy` 2 cycles later → no `ack`, all outputs stay at reset values.
- **Request withdrawn:** `req[0]` deasserted during WAIT → `ack[0]` still pulses once with the `do_in` value; `rr_ptr` advances to 1.

Source files
------------

// File: rtl/xadc_drp_arbiter_pkg.sv
// xadc_pkg: shared types and constants for the XADC DRP arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, DRP channel addresses, bus widths, timeout defaults.
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  // DRP channel addresses used by the consumers of this block
  localparam logic [DRP_AW-1:0] ADDR_TEMP  = 7'h00;
  localparam logic [DRP_AW-1:0] ADDR_VAUX6 = 7'h16;
  localparam logic [DRP_AW-1:0] ADDR_VAUX7 = 7'h17;

  localparam int TIMEOUT_DEFAULT = 255;

  // Data returned to a requester whose read never saw drdy
  localparam logic [DRP_DW-1:0] RDATA_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// xadc_drp_if: the DRP read bus between the arbiter (master) and xadc_wiz_0 (slave).
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; drdy marks the single response per den.
// Signals: daddr_out/den_out/dwe_out toward the XADC, drdy_in/do_in back from it.
interface xadc_drp_if;
  import xadc_pkg::*;

  logic [DRP_AW-1:0] daddr_out;
  logic              den_out;
  logic              dwe_out;
  logic              drdy_in;
  logic [DRP_DW-1:0] do_in;

  modport master (
    output daddr_out, den_out, dwe_out,
    input  drdy_in, do_in
  );

  modport slave (
    input  daddr_out, den_out, dwe_out,
    output drdy_in, do_in
  );

endinterface

// File: rtl/xadc_drp_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first set req at or above rr_ptr with wrap.
// Latency: zero (pure combinational).
// Backpressure: none; gnt_valid is low when no request is pending.
// Ports: req (one bit per requester), rr_ptr (search start), gnt_idx/gnt_valid (winner).
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_valid
);

  // One extra bit so rr_ptr + offset never overflows before the wrap subtract
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      idx = sum[PW-1:0];
      // Lowest offset from the pointer wins; later hits are ignored
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: round-robin sharing of the single XADC DRP read port among N_REQ requesters.
// Latency: den one cycle after req is seen; ack d cycles after den (d = drdy delay, capped at TIMEOUT).
// Backpressure: requests are levels held until ack; losers simply wait for a later grant.
// Ports: clk_100MHz, rst_n (sync, active-low), req/req_addr in, ack/err/rdata/busy out,
//        drp (master side of the DRP bus: daddr/den/dwe out, drdy/do in).
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [DRP_AW*N_REQ-1:0] req_addr,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DRP_DW-1:0]       rdata,
  output logic                    busy,
  xadc_drp_if.master              drp
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     g_q, g_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic [DRP_DW-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [DRP_AW-1:0] daddr_q, daddr_d;
  logic              den_q, den_d;

  logic [PW-1:0]     pick_idx;
  logic              pick_vld;
  logic [DRP_AW-1:0] addr_sel;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_picker (
    .req       (req),
    .rr_ptr    (ptr_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_vld)
  );

  // Address of the current winner, only meaningful when pick_vld
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        addr_sel = req_addr[DRP_AW*i +: DRP_AW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    daddr_d = daddr_q;
    den_d   = den_q;

    case (state_q)
      ST_IDLE: begin
        // drdy is deliberately not looked at here: late/spurious responses are dropped
        if (pick_vld) begin
          g_d     = pick_idx;
          daddr_d = addr_sel;
          den_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        den_d = 1'b0;
        // The read completes even if req[g] has been withdrawn meanwhile
        if (drp.drdy_in) begin
          rdata_d = drp.do_in;
          ack_d   = N_REQ'(1) << g_q;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = RDATA_TIMEOUT;
          ack_d   = N_REQ'(1) << g_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ack_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        ptr_d   = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      daddr_q <= '0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      daddr_q <= daddr_d;
      den_q   <= den_d;
    end
  end

  assign ack           = ack_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign drp.daddr_out = daddr_q;
  assign drp.den_out   = den_q;
  assign drp.dwe_out   = 1'b0;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb_xadc_drp_arbiter: randomized and directed stimulus against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk_100MHz = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]  ack;
  logic          err;
  logic [15:0]   rdata;
  logic          busy;

  logic [6:0]    addr [N];

  xadc_drp_if drp();

  xadc_drp_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .drp        (drp)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

  // XADC model: answers each den after model_d cycles (0 = never answers)
  int          model_d  = 0;
  logic [15:0] model_do = '0;
  int          rem      = 0;
  logic        m_drdy   = 1'b0;
  logic        s_drdy   = 1'b0;
  logic [15:0] s_do     = '0;

  always @(negedge clk_100MHz) begin
    m_drdy = 1'b0;
    if (drp.den_out) rem = model_d;
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) m_drdy = 1'b1;
    end
  end

  assign drp.drdy_in = m_drdy | s_drdy;
  assign drp.do_in   = m_drdy ? model_do : s_do;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: round-robin pointer and the last completed read data
  int          exp_ptr   = 0;
  logic [15:0] last_rd   = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_100MHz);
    #1;
  endtask

  // Winner = first pending requester at or after the pointer, wrapping
  function automatic int pick(input logic [N-1:0] r, input int p);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (p + i) % N;
      if (r[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic do_txn(input logic [N-1:0] r, input int d, input logic [15:0] data,
                        input bit withdraw);
    int w, lat, n;
    bit to, seen;
    logic [15:0] exp_rd;
    w      = pick(r, exp_ptr);
    to     = (d == 0) || (d > TO);
    lat    = to ? TO : d;
    exp_rd = to ? RDATA_TIMEOUT : data;
    model_d  = d;
    model_do = data;
    req      = r;
    tick;
    check("grant_den",  {31'b0, drp.den_out}, 32'd1);
    check("grant_busy", {31'b0, busy}, 32'd1);
    check("grant_addr", {25'b0, drp.daddr_out}, {25'b0, addr[w[1:0]]});
    check("grant_ack",  {28'b0, ack}, 32'd0);
    if (withdraw) req[w[1:0]] = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < lat + 4) begin
      tick;
      n++;
      if (n == 1) check("den_one_cycle", {31'b0, drp.den_out}, 32'd0);
      if (ack != '0) seen = 1'b1;
    end
    check("ack_seen",    {31'b0, seen}, 32'd1);
    check("ack_latency", n, lat);
    check("ack_onehot",  {28'b0, ack}, 32'(1) << w);
    check("ack_err",     {31'b0, err}, {31'b0, to});
    check("ack_rdata",   {16'b0, rdata}, {16'b0, exp_rd});
    check("ack_busy",    {31'b0, busy}, 32'd1);
    check("addr_stable", {25'b0, drp.daddr_out}, {25'b0, addr[w[1:0]]});
    req = '0;
    tick;
    check("done_ack",   {28'b0, ack}, 32'd0);
    check("done_err",   {31'b0, err}, 32'd0);
    check("done_busy",  {31'b0, busy}, 32'd0);
    check("done_rdata", {16'b0, rdata}, {16'b0, exp_rd});
    tick;
    check("idle_ack",   {28'b0, ack}, 32'd0);
    check("idle_rdata", {16'b0, rdata}, {16'b0, exp_rd});
    exp_ptr = (w + 1) % N;
    last_rd = exp_rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {28'b0, ack}, 32'd0);
    check({tag, "_err"},   {31'b0, err}, 32'd0);
    check({tag, "_rdata"}, {16'b0, rdata}, 32'd0);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check({tag, "_daddr"}, {25'b0, drp.daddr_out}, 32'd0);
    check({tag, "_den"},   {31'b0, drp.den_out}, 32'd0);
    check({tag, "_dwe"},   {31'b0, drp.dwe_out}, 32'd0);
  endtask

  initial begin
    int gw, grants, pend, idx;
    logic [N-1:0] prev;
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    tick;
    tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    addr[0] = ADDR_TEMP;
    addr[1] = ADDR_VAUX6;
    addr[2] = ADDR_VAUX7;
    addr[3] = 7'h03;

    // Single read: requester 1, drdy three cycles after den
    do_txn(4'b0010, 3, 16'hA5A0, 1'b0);
    // Timeout on requester 2, then a normal read from it
    do_txn(4'b0100, 0, 16'h0000, 1'b0);
    do_txn(4'b0100, 2, 16'h5A5A, 1'b0);

    // Spurious drdy while idle
    s_drdy = 1'b1;
    s_do   = 16'h1234;
    tick;
    s_drdy = 1'b0;
    check("spur_ack",   {28'b0, ack}, 32'd0);
    check("spur_rdata", {16'b0, rdata}, {16'b0, last_rd});
    tick;
    check("spur_rdata2", {16'b0, rdata}, {16'b0, last_rd});

    // Reset in the middle of WAIT, then a late drdy
    model_d = 0;
    req     = 4'b0100;
    tick;
    tick;
    rst_n = 1'b0;
    req   = '0;
    tick;
    check_reset_outputs("rst_wait");
    rst_n = 1'b1;
    tick;
    s_drdy = 1'b1;
    s_do   = 16'hBEEF;
    tick;
    s_drdy = 1'b0;
    check_reset_outputs("late_drdy");
    tick;
    check_reset_outputs("late_drdy2");
    exp_ptr = 0;
    last_rd = '0;

    // Request withdrawn during WAIT still completes; pointer then moves to 1
    do_txn(4'b0001, 4, 16'h0BEE, 1'b1);

    // Fairness: all requesting, each drops for one cycle after its ack
    model_do = 16'hC0DE;
    req      = 4'b1111;
    grants   = 0;
    pend     = -1;
    gw       = 0;
    for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
      model_d = $urandom_range(1, 4);
      prev    = req;
      tick;
      if (pend >= 0) begin
        req[pend[1:0]] = 1'b1;
        pend = -1;
      end
      if (drp.den_out) gw = pick(prev, exp_ptr);
      if (ack != '0) begin
        check("fair_winner", {28'b0, ack}, 32'(1) << gw);
        check("fair_rdata",  {16'b0, rdata}, {16'b0, model_do});
        check("fair_err",    {31'b0, err}, 32'd0);
        idx = gw;
        req[idx[1:0]] = 1'b0;
        pend    = idx;
        exp_ptr = (gw + 1) % N;
        grants++;
      end
    end
    check("fair_grants", grants, 8);
    req = '0;
    tick;
    tick;
    tick;
    last_rd = model_do;

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) addr[i] = 7'($urandom);
      r = 4'($urandom_range(1, 15));
      do_txn(r, $urandom_range(0, TO + 3), 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
